// File: rtl/vend_sequencer.sv
// Vending purchase/refund sequencer: price check, timed dispense, coin-by-coin change, then clears credit.
// Optional hopper ack watchdog with sticky FAULT state is enabled by defining VEND_ACK_TIMEOUT_EN.
module vend_sequencer #(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned PRICE0      = 3,
  parameter int unsigned PRICE1      = 5,
  parameter int unsigned PRICE2      = 12,
  parameter int unsigned PRICE3      = 25,
  parameter int unsigned DISP_CYC    = 8,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] credit,
  input  logic [1:0]       sel,
  input  logic             buy,
  input  logic             cancel,
  input  logic             coin_ack,
  output logic             dispense,
  output logic [1:0]       item,
  output logic             coin_req,
  output logic [1:0]       coin_val,
  output logic             credit_clr,
  output logic             err_funds,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state_dbg
);

  localparam int DC_W = $clog2(DISP_CYC + 1);

`ifdef VEND_ACK_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DISPENSE, S_CHG_REQ, S_CHG_GAP, S_CLEAR, S_FAULT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DISPENSE, S_CHG_REQ, S_CHG_GAP, S_CLEAR
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [DC_W-1:0]  disp_cnt_q, disp_cnt_d;
  logic [AMT_W-1:0] price;
  logic [1:0]       coin_code;
  logic [AMT_W-1:0] coin_amt;

  function automatic logic [AMT_W-1:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    return AMT_W'(PRICE0);
      2'd1:    return AMT_W'(PRICE1);
      2'd2:    return AMT_W'(PRICE2);
      default: return AMT_W'(PRICE3);
    endcase
  endfunction

  // Greedy pick: largest coin not exceeding the remaining change.
  function automatic logic [1:0] pick_coin(input logic [AMT_W-1:0] a);
    if (a >= AMT_W'(20))      return 2'd3;
    else if (a >= AMT_W'(10)) return 2'd2;
    else if (a >= AMT_W'(5))  return 2'd1;
    else                      return 2'd0;
  endfunction

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      2'd0:    return AMT_W'(1);
      2'd1:    return AMT_W'(5);
      2'd2:    return AMT_W'(10);
      default: return AMT_W'(20);
    endcase
  endfunction

  assign price     = price_of(sel_q);
  assign coin_code = pick_coin(amt_q);
  assign coin_amt  = coin_value(coin_code);
  assign state_dbg = state_q;

`ifdef VEND_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expired;

  // Restarts whenever CHG_REQ is left, so each coin request gets a full window.
  assign to_cnt_d   = (state_q == S_CHG_REQ) ? to_cnt_q + TO_W'(1) : '0;
  assign to_expired = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
  assign fault      = (state_q == S_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  logic [31:0] unused_ack_timeout;
  assign unused_ack_timeout = 32'(ACK_TIMEOUT);
  assign fault              = 1'b0;
`endif

  assign disp_cnt_d = (state_q == S_DISPENSE) ? disp_cnt_q + DC_W'(1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      amt_q      <= '0;
      disp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      amt_q      <= amt_d;
      disp_cnt_q <= disp_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    amt_d      = amt_q;
    dispense   = 1'b0;
    item       = 2'd0;
    coin_req   = 1'b0;
    coin_val   = 2'd0;
    credit_clr = 1'b0;
    err_funds  = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // Cancel has priority over a simultaneous buy.
        if (cancel) begin
          amt_d   = credit;
          state_d = (credit == '0) ? S_CLEAR : S_CHG_REQ;
        end else if (buy) begin
          sel_d   = sel;
          amt_d   = credit;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (amt_q >= price) begin
          amt_d   = amt_q - price;
          state_d = S_DISPENSE;
        end else begin
          err_funds = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DISPENSE: begin
        dispense = 1'b1;
        item     = sel_q;
        if (disp_cnt_q == DC_W'(DISP_CYC - 1))
          state_d = (amt_q != '0) ? S_CHG_REQ : S_CLEAR;
      end
      S_CHG_REQ: begin
        coin_req = 1'b1;
        coin_val = coin_code;
        if (coin_ack) begin
          amt_d   = amt_q - coin_amt;
          state_d = S_CHG_GAP;
        end
`ifdef VEND_ACK_TIMEOUT_EN
        else if (to_expired) begin
          state_d = S_FAULT;
        end
`endif
      end
      S_CHG_GAP: state_d = (amt_q != '0) ? S_CHG_REQ : S_CLEAR;
      S_CLEAR: begin
        credit_clr = 1'b1;
        state_d    = S_IDLE;
      end
`ifdef VEND_ACK_TIMEOUT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: transaction-level reference model builds a per-cycle
// expected queue (outputs plus the hopper ack to drive), compared with immediate assertions.
module tb_vend_sequencer;

  localparam int AMT_W       = 8;
  localparam int DISP_CYC    = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int W           = 11;

  logic             clk;
  logic             rst;
  logic [AMT_W-1:0] credit;
  logic [1:0]       sel;
  logic             buy;
  logic             cancel;
  logic             coin_ack;
  logic             dispense;
  logic [1:0]       item;
  logic             coin_req;
  logic [1:0]       coin_val;
  logic             credit_clr;
  logic             err_funds;
  logic             busy;
  logic             fault;
  logic [2:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry layout: [10] coin_ack to drive that cycle, [9:0] expected outputs.
  logic [W-1:0] exp_q[$];

  vend_sequencer #(
    .AMT_W(AMT_W), .PRICE0(3), .PRICE1(5), .PRICE2(12), .PRICE3(25),
    .DISP_CYC(DISP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .credit(credit), .sel(sel), .buy(buy), .cancel(cancel),
    .coin_ack(coin_ack), .dispense(dispense), .item(item), .coin_req(coin_req),
    .coin_val(coin_val), .credit_clr(credit_clr), .err_funds(err_funds), .busy(busy),
    .fault(fault), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [9:0] ow(input logic b, input logic d, input logic [1:0] it,
                                    input logic r, input logic [1:0] v, input logic c,
                                    input logic e);
    return {1'b0, b, d, it, r, v, c, e};
  endfunction

  // item/coin_val are only meaningful while their strobe is high.
  function automatic logic [9:0] obs();
    return {fault, busy, dispense, dispense ? item : 2'b00,
            coin_req, coin_req ? coin_val : 2'b00, credit_clr, err_funds};
  endfunction

  function automatic int unsigned price_tbl(input logic [1:0] s);
    int unsigned p[4] = '{3, 5, 12, 25};
    return p[s];
  endfunction

  task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic push_clear();
    exp_q.push_back({1'($urandom_range(0, 1)), ow(1, 0, 2'd0, 0, 2'd0, 1, 0)});
  endtask

  task automatic push_change(input int unsigned amount);
    int unsigned rem = amount;
    while (rem > 0) begin
      int unsigned v;
      logic [1:0]  code;
      int unsigned d;
      if (rem >= 20)      begin v = 20; code = 2'd3; end
      else if (rem >= 10) begin v = 10; code = 2'd2; end
      else if (rem >= 5)  begin v = 5;  code = 2'd1; end
      else                begin v = 1;  code = 2'd0; end
      d = $urandom_range(0, 3);
      for (int k = 0; k < int'(d); k++)
        exp_q.push_back({1'b0, ow(1, 0, 2'd0, 1, code, 0, 0)});
      exp_q.push_back({1'b1, ow(1, 0, 2'd0, 1, code, 0, 0)});
      rem -= v;
      exp_q.push_back({1'($urandom_range(0, 1)), ow(1, 0, 2'd0, 0, 2'd0, 0, 0)});
    end
  endtask

  task automatic build(input int unsigned c, input logic [1:0] s, input logic b, input logic x);
    int unsigned p;
    if (x) begin
      if (c != 0) push_change(c);
      push_clear();
    end else if (b) begin
      p = price_tbl(s);
      exp_q.push_back({1'($urandom_range(0, 1)), ow(1, 0, 2'd0, 0, 2'd0, 0, c < p)});
      if (c >= p) begin
        for (int k = 0; k < DISP_CYC; k++)
          exp_q.push_back({1'($urandom_range(0, 1)), ow(1, 1, s, 0, 2'd0, 0, 0)});
        if (c - p != 0) push_change(c - p);
        push_clear();
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input string name, input int unsigned c, input logic [1:0] s,
                         input logic b, input logic x);
    logic [W-1:0] e;
    int idx = 0;
    build(c, s, b, x);
    check({name, "_idle_before"}, obs(), 10'd0);
    credit = AMT_W'(c); sel = s; buy = b; cancel = x; coin_ack = 1'b0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check($sformatf("%s_cyc%0d", name, idx), obs(), e[9:0]);
      // Requests while busy and credit wiggles after the latch must be ignored.
      coin_ack = e[10];
      buy      = 1'($urandom_range(0, 1));
      cancel   = ($urandom_range(0, 3) == 0);
      credit   = AMT_W'($urandom);
      sel      = 2'($urandom);
      idx++;
    end
    @(posedge clk); #1;
    check({name, "_idle_after"}, obs(), 10'd0);
    buy = 1'b0; cancel = 1'b0; coin_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; credit = '0; sel = '0; buy = 1'b0; cancel = 1'b0; coin_ack = 1'b0;
    #1;
    check("reset_async", obs(), 10'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", obs(), 10'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_txn("buy12_sel2", 12, 2'd2, 1'b1, 1'b0);
    run_txn("buy38_sel1", 38, 2'd1, 1'b1, 1'b0);
    run_txn("buy4_sel1_short", 4, 2'd1, 1'b1, 1'b0);
    run_txn("buy_cancel_7", 7, 2'd0, 1'b1, 1'b1);
    run_txn("cancel_zero", 0, 2'd3, 1'b0, 1'b1);
    run_txn("buy_exact_5", 5, 2'd1, 1'b1, 1'b0);
    run_txn("buy_one_short", 2, 2'd0, 1'b1, 1'b0);
    run_txn("buy255_sel3", 255, 2'd3, 1'b1, 1'b0);
    run_txn("cancel255", 255, 2'd0, 1'b0, 1'b1);

    // Reset in the middle of a change payout.
    credit = 8'd47; cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("rst_pre_req", obs(), ow(1, 0, 2'd0, 1, 2'd3, 0, 0));
    #2 rst = 1'b0;
    #1;
    check("rst_mid_async", obs(), 10'd0);
    coin_ack = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_held", obs(), 10'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_late_ack", obs(), 10'd0);
    coin_ack = 1'b0;
    @(posedge clk); #1;
    check("rst_idle", obs(), 10'd0);
    run_txn("post_rst_buy", 20, 2'd2, 1'b1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int unsigned r  = $urandom_range(0, 7);
      int unsigned cr = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 60);
      logic [1:0]  s  = 2'($urandom);
      run_txn($sformatf("rnd%0d", t), cr, s, r >= 2, r <= 2);
    end

`ifdef VEND_ACK_TIMEOUT_EN
    credit = 8'd20; cancel = 1'b1; coin_ack = 1'b0;
    @(posedge clk); #1;
    cancel = 1'b0;
    for (int k = 0; k < ACK_TIMEOUT; k++) begin
      check($sformatf("to_req%0d", k), obs(), ow(1, 0, 2'd0, 1, 2'd3, 0, 0));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("to_fault%0d", k), obs(), {1'b1, ow(1, 0, 2'd0, 0, 2'd0, 0, 0)});
      buy = 1'b1; cancel = 1'b1; coin_ack = 1'b1;
      @(posedge clk); #1;
    end
    buy = 1'b0; cancel = 1'b0; coin_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("to_reset", obs(), 10'd0);
    @(posedge clk); #1;
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
